bus_master_seq: RTL
===================

// Module: bus_master_seq
// PURPOSE
//  Initiator engine for the M0 port of the shared BUS (master side facing the
//  BUS arbiter). Accepts one command at a time from a local client, requests the
//  bus, performs a single write or read beat to a slave (DMAC/Factorial/RAMs),
//  or waits on F_interrupt/D_interrupt, then returns a response with a status.
//  Replaces testbench-driven M0 stimulus so that full programs can run on-chip.
// PARAMETERS
//  RD_LAT   1     cycles from read address beat to M_din sample edge (>=1)
//  TIMEOUT  1024  max cycles waiting for grant or interrupt; 0 = never time out
//  TW       11    width of timeout counter (must hold TIMEOUT)
// PORTS
//  clk          in   1   system clock, all flops rising-edge
//  reset_n      in   1   asynchronous active-low reset
//  cmd_valid    in   1   command present
//  cmd_ready    out  1   engine can accept a command (high only in IDLE)
//  cmd_op       in   2   00 write, 01 read, 10 wait F_interrupt, 11 wait D_interrupt
//  cmd_addr     in   8   bus address (ops 00/01)
//  cmd_wdata    in   32  write data (op 00)
//  rsp_valid    out  1   one-cycle response pulse
//  rsp_rdata    out  32  read data (op 01), else 0
//  rsp_err      out  1   1 = timeout or grant lost; qualifies rsp_valid
//  busy         out  1   high in every state except IDLE
//  M0_req       out  1   bus request to arbiter
//  M0_grant     in   1   bus grant from arbiter
//  M0_wr        out  1   1 = write beat
//  M0_address   out  8   bus address
//  M0_dout      out  32  bus write data
//  M_din        in   32  bus read data
//  F_interrupt  in   1   factorial done interrupt (level)
//  D_interrupt  in   1   DMAC done interrupt (level)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except cmd_ready=1; internal regs cleared.
//  Handshake: command captured on edge where cmd_valid&&cmd_ready; op/addr/wdata
//   registered, inputs ignored afterwards until next IDLE.
//  States: IDLE, REQ, XFER, RDWAIT, WIRQ, DONE.
//  IDLE: cmd accepted -> REQ for ops 00/01, WIRQ for ops 10/11.
//  REQ: M0_req=1; timer counts. M0_grant=1 sampled -> XFER. Timer==TIMEOUT
//   (TIMEOUT!=0) -> DONE with err=1.
//  XFER: exactly one cycle; M0_req=1, M0_address=addr; op 00: M0_wr=1,
//   M0_dout=wdata -> DONE; op 01: M0_wr=0, M0_dout=0 -> RDWAIT.
//   M0_grant=0 in XFER -> DONE err=1 (write considered not performed).
//  RDWAIT: M0_req=1, M0_address held, M0_wr=0; count RD_LAT cycles after the
//   XFER edge, capture M_din on the RD_LAT-th edge -> DONE. Grant drop -> DONE err=1.
//  WIRQ: M0_req=0; selected interrupt sampled high -> DONE err=0; timeout ->
//   DONE err=1. Interrupt already high at entry completes in 1 cycle.
//  DONE: one cycle; M0_req=0, M0_wr=0, M0_address/M0_dout=0; rsp_valid=1 with
//   rsp_rdata/rsp_err; -> IDLE. rsp_rdata=0 on error or non-read ops.
//  Bus release: M0_req always drops for >=1 cycle (DONE) between transactions.
//  Timer: cleared on entry to REQ/WIRQ, saturates; never wraps.
//  M0_wr high only in XFER of a write, never with M0_req low.
//  Reset mid-operation: immediate return to IDLE, M0_req/M0_wr drop async, no
//   rsp_valid emitted for the aborted command.
// TESTING
//  1 Write op00 addr 0x21 data 0x0000_0005, grant after 2 cycles -> one beat
//    M0_wr=1 addr 0x21 dout 5; rsp_valid, err=0, total 1+2+1+1 cycles.
//  2 Read op01 addr 0x41, RD_LAT=1, bus returns 0xDEAD_BEEF -> rsp_rdata
//    0xDEADBEEF err=0; M0_wr stays 0 throughout.
//  3 Grant never asserted, TIMEOUT=8 -> rsp_valid err=1 after 8 REQ cycles,
//    no M0_wr pulse, M0_req low in DONE.
//  4 op10 with F_interrupt rising 5 cycles later -> rsp err=0 exactly one
//    cycle after sample; op11 with D_interrupt already high -> response in 2 cycles.
//  5 Grant dropped during RDWAIT -> err=1, rsp_rdata=0; next cmd accepted next cycle.
//  6 reset_n low during RDWAIT -> M0_req=0 async, no rsp_valid, cmd_ready=1
//    after release; back-to-back writes show M0_req gap of 1 cycle.

Source files
------------

// File: rtl/bus_master_seq.sv
// Single-beat bus initiator for the M0 port: takes one client command, arbitrates for
// the bus, performs one write/read beat or waits on an interrupt, and returns a response.
module bus_master_seq #(
   parameter int RD_LAT  = 1,
   parameter int TIMEOUT = 1024,
   parameter int TW      = 11
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [7:0]  cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic        M0_req,
   input  logic        M0_grant,
   output logic        M0_wr,
   output logic [7:0]  M0_address,
   output logic [31:0] M0_dout,
   input  logic [31:0] M_din,
   input  logic        F_interrupt,
   input  logic        D_interrupt
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_REQ    = 3'd1;
   localparam logic [2:0] S_XFER   = 3'd2;
   localparam logic [2:0] S_RDWAIT = 3'd3;
   localparam logic [2:0] S_WIRQ   = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   logic [2:0]    state;
   logic [1:0]    op_q;
   logic [7:0]    addr_q;
   logic [31:0]   wdata_q;
   logic [31:0]   rdata_q;
   logic          err_q;
   logic [TW-1:0] timer;
   logic [TW-1:0] timer_inc;
   logic [LW-1:0] lat_cnt;
   logic          timed_out;
   logic          irq_sel;

   // Saturating count of wait cycles; the limit is checked against the incremented value
   // so exactly TIMEOUT cycles are spent waiting before giving up.
   assign timer_inc = (&timer) ? timer : timer + 1'b1;
   assign timed_out = (TIMEOUT != 0) && (timer_inc == TW'(TIMEOUT));
   assign irq_sel   = op_q[0] ? D_interrupt : F_interrupt;

   // NOTE: every register here is state, so all updates are non-blocking and every
   // register (data included) is cleared by the async reset for a known post-reset view.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         timer   <= '0;
         lat_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  op_q    <= cmd_op;
                  addr_q  <= cmd_addr;
                  wdata_q <= cmd_wdata;
                  rdata_q <= '0;
                  err_q   <= 1'b0;
                  timer   <= '0;
                  lat_cnt <= '0;
                  state   <= cmd_op[1] ? S_WIRQ : S_REQ;
               end
            end
            S_REQ: begin
               if (M0_grant) begin
                  state <= S_XFER;
               end else if (timed_out) begin
                  err_q <= 1'b1;
                  state <= S_DONE;
               end else begin
                  timer <= timer_inc;
               end
            end
            S_XFER: begin
               lat_cnt <= '0;
               if (!M0_grant) begin
                  err_q <= 1'b1;
                  state <= S_DONE;
               end else begin
                  state <= op_q[0] ? S_RDWAIT : S_DONE;
               end
            end
            S_RDWAIT: begin
               if (!M0_grant) begin
                  err_q <= 1'b1;
                  state <= S_DONE;
               end else if (lat_cnt == LW'(RD_LAT - 1)) begin
                  rdata_q <= M_din;
                  state   <= S_DONE;
               end else begin
                  lat_cnt <= lat_cnt + 1'b1;
               end
            end
            S_WIRQ: begin
               if (irq_sel) begin
                  state <= S_DONE;
               end else if (timed_out) begin
                  err_q <= 1'b1;
                  state <= S_DONE;
               end else begin
                  timer <= timer_inc;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Outputs decode the state register only, so reset drops the bus request immediately.
   assign cmd_ready  = (state == S_IDLE);
   assign busy       = (state != S_IDLE);
   assign M0_req     = (state == S_REQ) || (state == S_XFER) || (state == S_RDWAIT);
   assign M0_wr      = (state == S_XFER) && !op_q[0];
   assign M0_address = ((state == S_XFER) || (state == S_RDWAIT)) ? addr_q : 8'h00;
   assign M0_dout    = M0_wr ? wdata_q : 32'h0;
   assign rsp_valid  = (state == S_DONE);
   assign rsp_err    = (state == S_DONE) && err_q;
   assign rsp_rdata  = (state == S_DONE) ? rdata_q : 32'h0;

endmodule
